// File: rtl/reset_sequencer.sv
// reset_sequencer: staged per-domain reset release with fault/timeout lockout and reverse-order soft drain
module reset_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int REL_DLY    = 50000,
    parameter int ACK_TMO    = 5000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_STAGES-1:0]         stage_ack,
    input  logic                          soft_rst_req,
    input  logic                          fault,
    output logic [NUM_STAGES-1:0]         stage_rst_n,
    output logic                          all_ready,
    output logic                          busy,
    output logic [1:0]                    err_code,
    output logic [$clog2(NUM_STAGES)-1:0] err_stage
);
    localparam int IW   = $clog2(NUM_STAGES);
    localparam int CMAX = (REL_DLY > ACK_TMO) ? REL_DLY : ACK_TMO;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] REL_LAST = CW'(REL_DLY - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TMO - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);
    localparam logic [1:0] E_NONE = 2'b00, E_TMO = 2'b01, E_FAULT = 2'b10, E_LOST = 2'b11;

    typedef enum logic [2:0] {HOLD, DLY, ACK, RUN, DRAIN, ERR} state_t;

    state_t                r_state, w_state_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt, r_err_stage, w_err_stage_nxt, w_low;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [NUM_STAGES-1:0] r_rst, w_rst_nxt, w_drained;
    logic [1:0]            r_err_code, w_err_code_nxt;
    logic                  r_all_ready, w_all_ready_nxt, r_busy, w_busy_nxt;

    assign stage_rst_n = r_rst;
    assign all_ready   = r_all_ready;
    assign busy        = r_busy;
    assign err_code    = r_err_code;
    assign err_stage   = r_err_stage;

    // Released stages always form a contiguous run from bit 0, so dropping the highest is a shift
    assign w_drained = r_rst >> 1;

    always_comb begin
        w_low = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--)
            if (!stage_ack[k]) w_low = IW'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HOLD;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rst       <= '0;
            r_err_code  <= E_NONE;
            r_err_stage <= '0;
            r_all_ready <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rst       <= w_rst_nxt;
            r_err_code  <= w_err_code_nxt;
            r_err_stage <= w_err_stage_nxt;
            r_all_ready <= w_all_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_rst_nxt       = r_rst;
        w_err_code_nxt  = r_err_code;
        w_err_stage_nxt = r_err_stage;
        if (fault && r_state != ERR) begin
            w_state_nxt     = ERR;
            w_rst_nxt       = '0;
            w_err_code_nxt  = E_FAULT;
            w_err_stage_nxt = r_idx;
        end else if (soft_rst_req && (r_state == DLY || r_state == ACK || r_state == RUN)) begin
            w_rst_nxt   = w_drained;
            w_state_nxt = (w_drained == '0) ? HOLD : DRAIN;
        end else begin
            case (r_state)
                HOLD: w_state_nxt = DLY;
                DLY: begin
                    if (r_cnt == REL_LAST) begin
                        w_rst_nxt[r_idx] = 1'b1;
                        w_state_nxt      = ACK;
                    end else
                        w_cnt_nxt = r_cnt + CW'(1);
                end
                ACK: begin
                    if (stage_ack[r_idx]) begin
                        w_state_nxt = (r_idx == IDX_LAST) ? RUN : DLY;
                        w_idx_nxt   = (r_idx == IDX_LAST) ? r_idx : r_idx + IW'(1);
                    end else if (r_cnt == TMO_LAST) begin
                        w_state_nxt     = ERR;
                        w_rst_nxt       = '0;
                        w_err_code_nxt  = E_TMO;
                        w_err_stage_nxt = r_idx;
                    end else
                        w_cnt_nxt = r_cnt + CW'(1);
                end
                RUN: begin
                    if (!(&stage_ack)) begin
                        w_state_nxt     = ERR;
                        w_rst_nxt       = '0;
                        w_err_code_nxt  = E_LOST;
                        w_err_stage_nxt = w_low;
                    end
                end
                DRAIN: begin
                    if (r_cnt == REL_LAST) begin
                        w_rst_nxt   = w_drained;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_drained == '0) ? HOLD : DRAIN;
                    end else
                        w_cnt_nxt = r_cnt + CW'(1);
                end
                ERR: begin
                    if (soft_rst_req && !fault) begin
                        w_state_nxt     = HOLD;
                        w_err_code_nxt  = E_NONE;
                        w_err_stage_nxt = '0;
                    end
                end
                default: w_state_nxt = HOLD;
            endcase
        end
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
        if (w_state_nxt == HOLD) w_idx_nxt = '0;
    end

    always_comb begin
        w_all_ready_nxt = (w_state_nxt == RUN);
        w_busy_nxt      = !(w_state_nxt == RUN || w_state_nxt == ERR);
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus, per-cycle comparison against a stage-count model, plus literal timing pins
module tb_reset_sequencer;
    localparam int N = 3, RD = 4, TMO = 8;
    localparam int M_HOLD = 0, M_DLY = 1, M_ACK = 2, M_RUN = 3, M_DRAIN = 4, M_ERR = 5;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] stage_ack = '1;
    logic         soft_rst_req = 1'b0, fault = 1'b0;
    logic [N-1:0] stage_rst_n;
    logic         all_ready, busy;
    logic [1:0]   err_code;
    logic [1:0]   err_stage;

    int checks = 0, errors = 0;
    int m_mode, m_rel, m_idx, m_t, m_code, m_estage;

    reset_sequencer #(.NUM_STAGES(N), .REL_DLY(RD), .ACK_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .stage_ack(stage_ack), .soft_rst_req(soft_rst_req), .fault(fault),
        .stage_rst_n(stage_rst_n), .all_ready(all_ready), .busy(busy), .err_code(err_code), .err_stage(err_stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model tracks how many stages are released rather than a reset vector
    task model_reset();
        m_mode = M_HOLD; m_rel = 0; m_idx = 0; m_t = 0; m_code = 0; m_estage = 0;
    endtask

    task model_step();
        if (m_mode != M_ERR && fault) begin
            m_mode = M_ERR; m_code = 2; m_estage = m_idx; m_rel = 0; m_t = 0;
        end else if (soft_rst_req && (m_mode == M_DLY || m_mode == M_ACK || m_mode == M_RUN)) begin
            m_t = 0;
            if (m_rel > 0) m_rel--;
            m_mode = (m_rel == 0) ? M_HOLD : M_DRAIN;
            if (m_mode == M_HOLD) m_idx = 0;
        end else if (m_mode == M_HOLD) begin
            m_mode = M_DLY; m_idx = 0; m_t = 0;
        end else if (m_mode == M_DLY) begin
            if (m_t == RD - 1) begin m_rel++; m_t = 0; m_mode = M_ACK; end
            else m_t++;
        end else if (m_mode == M_ACK) begin
            if (stage_ack[m_idx]) begin
                m_t = 0;
                if (m_idx == N - 1) m_mode = M_RUN;
                else begin m_idx++; m_mode = M_DLY; end
            end else if (m_t == TMO - 1) begin
                m_mode = M_ERR; m_code = 1; m_estage = m_idx; m_rel = 0; m_t = 0;
            end else m_t++;
        end else if (m_mode == M_RUN) begin
            if (stage_ack != {N{1'b1}}) begin
                m_mode = M_ERR; m_code = 3; m_rel = 0;
                for (int k = N - 1; k >= 0; k--) if (!stage_ack[k]) m_estage = k;
            end
        end else if (m_mode == M_DRAIN) begin
            if (m_t == RD - 1) begin
                m_rel--; m_t = 0;
                if (m_rel == 0) begin m_mode = M_HOLD; m_idx = 0; end
            end else m_t++;
        end else if (m_mode == M_ERR && soft_rst_req && !fault) begin
            m_mode = M_HOLD; m_code = 0; m_estage = 0; m_idx = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("stage_rst_n", 32'(stage_rst_n), 32'((1 << m_rel) - 1));
            chk("all_ready", 32'(all_ready), 32'(m_mode == M_RUN));
            chk("busy", 32'(busy), 32'(m_mode != M_RUN && m_mode != M_ERR));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("err_stage", 32'(err_stage), 32'(m_estage));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        step(3);
        chk("rst_stage", 32'(stage_rst_n), 0);
        chk("rst_ready", 32'(all_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_code", 32'(err_code), 0);
        chk("rst_estage", 32'(err_stage), 0);
        rst_n = 1'b1;
        // Normal bring-up with all acks tied high
        step(5);  chk("t1_c5_stage", 32'(stage_rst_n), 32'b001);
        step(5);  chk("t1_c10_stage", 32'(stage_rst_n), 32'b011);
        step(5);  chk("t1_c15_stage", 32'(stage_rst_n), 32'b111);
        chk("t1_c15_ready", 32'(all_ready), 0);
        step(1);  chk("t1_c16_ready", 32'(all_ready), 1);
        chk("t1_c16_busy", 32'(busy), 0);
        // Ready lost on stage 0
        stage_ack = 3'b110;
        step(1);  chk("t6_stage", 32'(stage_rst_n), 0);
        chk("t6_code", 32'(err_code), 3);
        chk("t6_estage", 32'(err_stage), 0);
        stage_ack = 3'b111;
        pulse_soft();
        chk("t6_clr_code", 32'(err_code), 0);
        chk("t6_clr_busy", 32'(busy), 1);
        step(16); chk("t6_rerun_ready", 32'(all_ready), 1);
        // Fault in RUN, soft request masked while fault held
        fault = 1'b1;
        step(1);  chk("t3_stage", 32'(stage_rst_n), 0);
        chk("t3_code", 32'(err_code), 2);
        chk("t3_estage", 32'(err_stage), 2);
        pulse_soft();
        chk("t3_masked_code", 32'(err_code), 2);
        fault = 1'b0;
        step(1);  chk("t3_hold_code", 32'(err_code), 2);
        pulse_soft();
        chk("t3_clr_code", 32'(err_code), 0);
        step(15); chk("t3_c15_stage", 32'(stage_rst_n), 32'b111);
        chk("t3_c15_ready", 32'(all_ready), 0);
        step(1);  chk("t3_c16_ready", 32'(all_ready), 1);
        // Soft drain from RUN
        pulse_soft();
        chk("t4_d0_stage", 32'(stage_rst_n), 32'b011);
        chk("t4_d0_ready", 32'(all_ready), 0);
        step(3);  chk("t4_d3_stage", 32'(stage_rst_n), 32'b011);
        step(1);  chk("t4_d4_stage", 32'(stage_rst_n), 32'b001);
        step(4);  chk("t4_d8_stage", 32'(stage_rst_n), 32'b000);
        chk("t4_d8_busy", 32'(busy), 1);
        step(16); chk("t4_rerun_ready", 32'(all_ready), 1);
        // Stage 1 never acks: timeout after resequence
        stage_ack = 3'b101;
        pulse_soft();
        step(8);  chk("t2_drained", 32'(stage_rst_n), 0);
        step(10); chk("t2_c10_stage", 32'(stage_rst_n), 32'b011);
        step(7);  chk("t2_c17_code", 32'(err_code), 0);
        step(1);  chk("t2_c18_stage", 32'(stage_rst_n), 0);
        chk("t2_c18_code", 32'(err_code), 1);
        chk("t2_c18_estage", 32'(err_stage), 1);
        chk("t2_c18_busy", 32'(busy), 0);
        // Soft request in DLY with nothing released goes straight to HOLD
        stage_ack = 3'b111;
        pulse_soft();
        step(2);
        pulse_soft();
        chk("dly_soft_busy", 32'(busy), 1);
        step(7);  chk("t5_pre_stage", 32'(stage_rst_n), 32'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_stage", 32'(stage_rst_n), 0);
        chk("t5_async_ready", 32'(all_ready), 0);
        chk("t5_async_busy", 32'(busy), 1);
        step(2);
        rst_n = 1'b1;
        step(16); chk("t5_rerun_ready", 32'(all_ready), 1);
        // Fault during DRAIN: no further drain, straight to ERR
        pulse_soft();
        step(2);
        fault = 1'b1;
        step(1);
        fault = 1'b0;
        chk("drain_fault_stage", 32'(stage_rst_n), 0);
        chk("drain_fault_code", 32'(err_code), 2);
        pulse_soft();
        step(16); chk("final_ready", 32'(all_ready), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
